// File: rtl/line_drawer.sv
// rtl/line_drawer.sv - Bresenham line rasteriser, one clipped pixel write per clock
// Outputs are registered and reflect the current state: SETUP, one DRAW cycle per pixel, then DONE.
module line_drawer #(
  parameter int WIDTH    = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             color,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             pixel_color,
  output logic             pixel_write,
  output logic             busy,
  output logic             done
);

  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] MAX_X = WIDTH'(SCREEN_W);
  localparam logic [WIDTH-1:0] MAX_Y = WIDTH'(SCREEN_H);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_FIN} state_t;

  state_t                 state;
  logic [WIDTH-1:0]       rx0, ry0, rx1, ry1;
  logic                   steep, ydec;
  logic [WIDTH-1:0]       cur_x, cur_y, end_x;
  logic signed [SW-1:0]   dx_r, dy_r, err;

  logic [WIDTH-1:0]       adx, ady, ax0, ay0, ax1, ay1;
  logic [WIDTH-1:0]       sx0, sy0, sx1, sy1, s_dx, s_dy;
  logic                   s_steep, s_swap;
  logic signed [SW-1:0]   s_err;
  logic [WIDTH-1:0]       s_ox, s_oy;
  logic                   s_vis;

  logic signed [SW-1:0]   err_a, err_n;
  logic                   step_y;
  logic [WIDTH-1:0]       nx, ny, n_ox, n_oy;
  logic                   n_vis;

  // Endpoint normalisation for SETUP, computed from the latched command
  always_comb begin
    adx     = (rx1 >= rx0) ? rx1 - rx0 : rx0 - rx1;
    ady     = (ry1 >= ry0) ? ry1 - ry0 : ry0 - ry1;
    s_steep = ady > adx;
    ax0     = s_steep ? ry0 : rx0;
    ay0     = s_steep ? rx0 : ry0;
    ax1     = s_steep ? ry1 : rx1;
    ay1     = s_steep ? rx1 : ry1;
    s_swap  = ax0 > ax1;
    sx0     = s_swap ? ax1 : ax0;
    sy0     = s_swap ? ay1 : ay0;
    sx1     = s_swap ? ax0 : ax1;
    sy1     = s_swap ? ay0 : ay1;
    s_dx    = sx1 - sx0;
    s_dy    = (sy1 >= sy0) ? sy1 - sy0 : sy0 - sy1;
    s_err   = -$signed({3'b000, s_dx[WIDTH-1:1]});
    s_ox    = s_steep ? sy0 : sx0;
    s_oy    = s_steep ? sx0 : sy0;
    s_vis   = (s_ox < MAX_X) && (s_oy < MAX_Y);
  end

  always_comb begin
    err_a  = err + dy_r;
    step_y = !err_a[SW-1];
    err_n  = step_y ? err_a - dx_r : err_a;
    nx     = cur_x + ONE;
    ny     = step_y ? (ydec ? cur_y - ONE : cur_y + ONE) : cur_y;
    n_ox   = steep ? ny : nx;
    n_oy   = steep ? nx : ny;
    n_vis  = (n_ox < MAX_X) && (n_oy < MAX_Y);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rx0         <= '0;
      ry0         <= '0;
      rx1         <= '0;
      ry1         <= '0;
      steep       <= 1'b0;
      ydec        <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      end_x       <= '0;
      dx_r        <= '0;
      dy_r        <= '0;
      err         <= '0;
      x           <= '0;
      y           <= '0;
      pixel_color <= 1'b0;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done        <= 1'b0;
          pixel_write <= 1'b0;
          if (start) begin
            rx0         <= x0;
            ry0         <= y0;
            rx1         <= x1;
            ry1         <= y1;
            pixel_color <= color;
            busy        <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          steep       <= s_steep;
          ydec        <= !(sy0 < sy1);
          cur_x       <= sx0;
          cur_y       <= sy0;
          end_x       <= sx1;
          dx_r        <= $signed({2'b00, s_dx});
          dy_r        <= $signed({2'b00, s_dy});
          err         <= s_err;
          x           <= s_ox;
          y           <= s_oy;
          pixel_write <= s_vis;
          state       <= S_DRAW;
        end
        S_DRAW: begin
          // The pixel for cur_x is on the outputs now; advance or finish
          if (cur_x == end_x) begin
            pixel_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_FIN;
          end else begin
            cur_x       <= nx;
            cur_y       <= ny;
            err         <= err_n;
            x           <= n_ox;
            y           <= n_oy;
            pixel_write <= n_vis;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
